mc_control_fsm: RTL and testbench

Multicycle control unit for the MIPS-subset datapath. A Moore state machine walks each instruction through fetch, decode, execute, memory and writeback. It drives every datapath enable and mux select, including the 2-bit ALU B-source select (00 = reg B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2). It sits between the instruction register and the datapath, and inserts memory wait cycles for a configurable memory latency.

---
 rtl/mc_control_fsm.sv | 215 +++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// Multicycle Moore control unit for the MIPS-subset datapath.
// Walks each instruction through fetch/decode/execute/memory/writeback and drives all datapath controls.
module mc_control_fsm #(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    output logic       pc_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       a_write,
    output logic       b_write,
    output logic       alu_out_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       overflow_trap,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_RESET     = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_EXEC_R    = 4'd3,
        S_WB_R      = 4'd4,
        S_EXEC_I    = 4'd5,
        S_WB_I      = 4'd6,
        S_MEM_ADDR  = 4'd7,
        S_MEM_READ  = 4'd8,
        S_MEM_WB    = 4'd9,
        S_MEM_WRITE = 4'd10,
        S_BRANCH    = 4'd11,
        S_JUMP      = 4'd12,
        S_TRAP      = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [3:0] WAIT_LAST = 4'(MEM_LATENCY - 1);

    state_t     state_q, state_d;
    logic [3:0] wait_cnt;
    logic       ovf_q;
    logic       illegal_q;
    logic       wait_last;
    logic       r_legal;
    logic       r_addsub;
    logic [2:0] r_alu_op;

    assign wait_last = (wait_cnt == WAIT_LAST);
    assign r_addsub  = (funct == 6'h20) || (funct == 6'h22);

    always_comb begin
        r_legal  = 1'b1;
        r_alu_op = 3'b000;
        case (funct)
            6'h20:   r_alu_op = ALU_ADD;
            6'h22:   r_alu_op = ALU_SUB;
            6'h24:   r_alu_op = ALU_AND;
            6'h25:   r_alu_op = ALU_OR;
            6'h2A:   r_alu_op = ALU_SLT;
            default: r_legal  = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_RESET;
            wait_cnt  <= 4'd0;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) wait_cnt <= 4'd0;
            else if (!wait_last)    wait_cnt <= wait_cnt + 4'd1;
            // Only add/sub/addi may suppress writeback; and/or/slt never trap.
            if (state_q == S_EXEC_I)      ovf_q <= overflow;
            else if (state_q == S_EXEC_R) ovf_q <= overflow && r_addsub;
            if (state_d == S_TRAP) illegal_q <= 1'b1;
        end
    end

    // NOTE: every combinational output gets a default first so no latches are inferred.
    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        a_write       = 1'b0;
        b_write       = 1'b0;
        alu_out_write = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 3'b000;
        pc_source     = 2'b00;
        instr_done    = 1'b0;
        overflow_trap = 1'b0;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = ALU_ADD;
                if (wait_last) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b     = 2'b11;
                alu_op        = ALU_ADD;
                alu_out_write = 1'b1;
                a_write       = 1'b1;
                b_write       = 1'b1;
                case (opcode)
                    OP_RTYPE:      state_d = r_legal ? S_EXEC_R : S_TRAP;
                    OP_ADDI:       state_d = S_EXEC_I;
                    OP_LW, OP_SW:  state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
                    default:       state_d = S_TRAP;
                endcase
            end
            S_EXEC_R: begin
                alu_src_a     = 1'b1;
                alu_op        = r_alu_op;
                alu_out_write = 1'b1;
                state_d       = S_WB_R;
            end
            S_WB_R, S_WB_I: begin
                reg_dst       = (state_q == S_WB_R);
                instr_done    = 1'b1;
                reg_write     = !ovf_q;
                overflow_trap = ovf_q;
                state_d       = S_FETCH;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                alu_src_a     = 1'b1;
                alu_src_b     = 2'b10;
                alu_op        = ALU_ADD;
                alu_out_write = 1'b1;
                if (state_q == S_EXEC_I)  state_d = S_WB_I;
                else if (opcode == OP_SW) state_d = S_MEM_WRITE;
                else                      state_d = S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                if (wait_last) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                if (wait_last) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = ALU_SUB;
                pc_source  = 2'b01;
                instr_done = 1'b1;
                pc_write   = (opcode == OP_BNE) ? !zero : zero;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pc_source  = 2'b10;
                pc_write   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_RESET;
        endcase
    end

    assign illegal_op = illegal_q;
    assign state      = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: three instances (L=1, 3, 4) share stimulus; the
// driver queues hand-computed per-cycle outputs and a monitor compares them on the falling edge.
module tb_mc_control_fsm;

    typedef struct packed {
        logic       pc_write;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       a_write;
        logic       b_write;
        logic       alu_out_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       overflow_trap;
        logic       illegal_op;
        logic [3:0] state;
    } outs_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       overflow;
    outs_t      obs [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic       pc_write, mem_read, mem_write, ir_write, a_write, b_write, alu_out_write;
        logic       reg_write, reg_dst, mem_to_reg, alu_src_a, instr_done, overflow_trap, illegal_op;
        logic [1:0] alu_src_b, pc_source;
        logic [2:0] alu_op;
        logic [3:0] state;
        mc_control_fsm #(.MEM_LATENCY((g == 0) ? 1 : (g == 1) ? 3 : 4)) dut (
            .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct),
            .zero(zero), .overflow(overflow),
            .pc_write(pc_write), .mem_read(mem_read), .mem_write(mem_write),
            .ir_write(ir_write), .a_write(a_write), .b_write(b_write),
            .alu_out_write(alu_out_write), .reg_write(reg_write), .reg_dst(reg_dst),
            .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
            .alu_op(alu_op), .pc_source(pc_source), .instr_done(instr_done),
            .overflow_trap(overflow_trap), .illegal_op(illegal_op), .state(state)
        );
        assign obs[g] = {pc_write, mem_read, mem_write, ir_write, a_write, b_write,
                         alu_out_write, reg_write, reg_dst, mem_to_reg, alu_src_a,
                         alu_src_b, alu_op, pc_source, instr_done, overflow_trap,
                         illegal_op, state};
    end

    outs_t exp_q  [$];
    int    sel_q  [$];
    string name_q [$];
    int    sel = 0;
    int    vectors = 0;
    int    miscompares = 0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            outs_t e;
            int    s;
            string n;
            e = exp_q.pop_front();
            s = sel_q.pop_front();
            n = name_q.pop_front();
            vectors++;
            if (obs[s] !== e) begin
                miscompares++;
                $display("FAIL %s (L-instance %0d): got state=%0d bits=%h, expected state=%0d bits=%h",
                         n, s, obs[s].state, obs[s], e.state, e);
            end
        end
    end

    task automatic step(input outs_t e, input string n);
        exp_q.push_back(e);
        sel_q.push_back(sel);
        name_q.push_back(n);
        @(posedge clk);
        #1;
    endtask

    function automatic outs_t x_idle(input logic [3:0] st);
        outs_t x = '0;
        x.state = st;
        return x;
    endfunction

    function automatic outs_t x_fetch(input logic last);
        outs_t x = x_idle(4'd1);
        x.mem_read  = 1'b1;
        x.alu_src_b = 2'b01;
        x.alu_op    = 3'b001;
        x.ir_write  = last;
        x.pc_write  = last;
        return x;
    endfunction

    function automatic outs_t x_decode();
        outs_t x = x_idle(4'd2);
        x.alu_src_b     = 2'b11;
        x.alu_op        = 3'b001;
        x.alu_out_write = 1'b1;
        x.a_write       = 1'b1;
        x.b_write       = 1'b1;
        return x;
    endfunction

    function automatic outs_t x_exec(input logic [3:0] st, input logic [1:0] sb, input logic [2:0] op);
        outs_t x = x_idle(st);
        x.alu_src_a     = 1'b1;
        x.alu_src_b     = sb;
        x.alu_op        = op;
        x.alu_out_write = 1'b1;
        return x;
    endfunction

    function automatic outs_t x_wb(input logic [3:0] st, input logic rd, input logic sup);
        outs_t x = x_idle(st);
        x.reg_dst       = rd;
        x.instr_done    = 1'b1;
        x.reg_write     = !sup;
        x.overflow_trap = sup;
        return x;
    endfunction

    function automatic outs_t x_branch(input logic pcw);
        outs_t x = x_idle(4'd11);
        x.alu_src_a  = 1'b1;
        x.alu_op     = 3'b010;
        x.pc_source  = 2'b01;
        x.instr_done = 1'b1;
        x.pc_write   = pcw;
        return x;
    endfunction

    function automatic outs_t x_mem(input logic [3:0] st, input logic done);
        outs_t x = x_idle(st);
        x.mem_read   = (st == 4'd8);
        x.mem_write  = (st == 4'd10);
        x.reg_write  = (st == 4'd9);
        x.mem_to_reg = (st == 4'd9);
        x.instr_done = done;
        return x;
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        step(x_idle(4'd0), "reset_hold0");
        step(x_idle(4'd0), "reset_hold1");
        reset_n = 1'b1;
        step(x_idle(4'd0), "reset_release");
    endtask

    initial begin
        outs_t x;
        reset_n  = 1'b0;
        opcode   = 6'h00;
        funct    = 6'h20;
        zero     = 1'b0;
        overflow = 1'b0;
        @(posedge clk);
        #1;

        // L=1: reset, then add / sub-overflow / and-overflow
        sel = 0;
        do_reset();
        step(x_fetch(1'b1), "add_fetch");
        step(x_decode(), "add_decode");
        step(x_exec(4'd3, 2'b00, 3'b001), "add_exec");
        step(x_wb(4'd4, 1'b1, 1'b0), "add_wb");
        funct = 6'h22;
        step(x_fetch(1'b1), "sub_fetch");
        step(x_decode(), "sub_decode");
        overflow = 1'b1;
        step(x_exec(4'd3, 2'b00, 3'b010), "sub_exec");
        overflow = 1'b0;
        step(x_wb(4'd4, 1'b1, 1'b1), "sub_wb_suppressed");
        funct = 6'h24;
        step(x_fetch(1'b1), "and_fetch");
        step(x_decode(), "and_decode");
        overflow = 1'b1;
        step(x_exec(4'd3, 2'b00, 3'b011), "and_exec");
        overflow = 1'b0;
        step(x_wb(4'd4, 1'b1, 1'b0), "and_wb_not_suppressed");

        // beq zero=1, then bne zero=1
        opcode = 6'h04;
        zero   = 1'b1;
        step(x_fetch(1'b1), "beq_fetch");
        step(x_decode(), "beq_decode");
        step(x_branch(1'b1), "beq_taken");
        opcode = 6'h05;
        step(x_fetch(1'b1), "bne_fetch");
        step(x_decode(), "bne_decode");
        step(x_branch(1'b0), "bne_not_taken");
        zero = 1'b0;

        // addi with overflow
        opcode = 6'h08;
        step(x_fetch(1'b1), "addi_fetch");
        step(x_decode(), "addi_decode");
        overflow = 1'b1;
        step(x_exec(4'd5, 2'b10, 3'b001), "addi_exec");
        overflow = 1'b0;
        step(x_wb(4'd6, 1'b0, 1'b1), "addi_wb_suppressed");

        // j, then sw with L=1
        opcode = 6'h02;
        step(x_fetch(1'b1), "j_fetch");
        step(x_decode(), "j_decode");
        x = x_idle(4'd12);
        x.pc_source  = 2'b10;
        x.pc_write   = 1'b1;
        x.instr_done = 1'b1;
        step(x, "j_jump");
        opcode = 6'h2B;
        step(x_fetch(1'b1), "sw1_fetch");
        step(x_decode(), "sw1_decode");
        step(x_exec(4'd7, 2'b10, 3'b001), "sw1_mem_addr");
        step(x_mem(4'd10, 1'b1), "sw1_mem_write");

        // illegal opcode: TRAP, illegal_op sticky even with a legal opcode present
        opcode = 6'h3F;
        step(x_fetch(1'b1), "ill_fetch");
        step(x_decode(), "ill_decode");
        x = x_idle(4'd13);
        x.illegal_op = 1'b1;
        step(x, "trap0");
        opcode = 6'h00;
        funct  = 6'h20;
        step(x, "trap1_sticky");
        step(x, "trap2_sticky");

        // unsupported funct after reset also traps
        do_reset();
        funct = 6'h21;
        step(x_fetch(1'b1), "badfunct_fetch");
        step(x_decode(), "badfunct_decode");
        step(x, "badfunct_trap");

        // L=3: lw
        sel = 1;
        do_reset();
        opcode = 6'h23;
        step(x_fetch(1'b0), "lw_fetch0");
        step(x_fetch(1'b0), "lw_fetch1");
        step(x_fetch(1'b1), "lw_fetch2");
        step(x_decode(), "lw_decode");
        step(x_exec(4'd7, 2'b10, 3'b001), "lw_mem_addr");
        step(x_mem(4'd8, 1'b0), "lw_mem_read0");
        step(x_mem(4'd8, 1'b0), "lw_mem_read1");
        step(x_mem(4'd8, 1'b0), "lw_mem_read2");
        step(x_mem(4'd9, 1'b1), "lw_mem_wb");
        step(x_fetch(1'b0), "lw_next_fetch");

        // L=4: sw interrupted by reset in the 2nd MEM_WRITE cycle
        sel = 2;
        do_reset();
        opcode = 6'h2B;
        step(x_fetch(1'b0), "sw4_fetch0");
        step(x_fetch(1'b0), "sw4_fetch1");
        step(x_fetch(1'b0), "sw4_fetch2");
        step(x_fetch(1'b1), "sw4_fetch3");
        step(x_decode(), "sw4_decode");
        step(x_exec(4'd7, 2'b10, 3'b001), "sw4_mem_addr");
        step(x_mem(4'd10, 1'b0), "sw4_mem_write0");
        do_reset();
        step(x_fetch(1'b0), "sw4_restart_fetch");

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
